// File: rtl/fwrisc_mem_arbiter.sv
// Shares one memory port between the fwrisc fetch and data ports; grant is held until mready or timeout.
// Build option: define FWRISC_MEM_ARB_RR_EN for round-robin arbitration (default: data has fixed priority).
module fwrisc_mem_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 0,
  parameter logic [31:0] TO_RDATA       = 32'hDEADBEEF
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        ivalid,
  input  logic [31:0] iaddr,
  output logic        iready,
  output logic [31:0] idata,
  input  logic        dvalid,
  input  logic [31:0] daddr,
  input  logic [31:0] dwdata,
  input  logic [3:0]  dwstb,
  input  logic        dwrite,
  output logic        dready,
  output logic [31:0] drdata,
  output logic        mvalid,
  output logic [31:0] maddr,
  output logic [31:0] mwdata,
  output logic [3:0]  mwstb,
  output logic        mwrite,
  input  logic [31:0] mrdata,
  input  logic        mready,
  output logic        busy,
  output logic        to_err
);

  typedef enum logic [1:0] {IDLE, GNT_I, GNT_D} state_e;

  localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYCLES - 1);

  state_e      r_state;
  state_e      w_next;
  logic [15:0] r_cnt;
  logic        w_owner_valid;
  logic        w_to;
  logic        w_done;
  logic        w_pick_d;

`ifdef FWRISC_MEM_ARB_RR_EN
  logic r_last_d;

  always_ff @(posedge clock) begin
    if (reset)       r_last_d <= 1'b0;
    else if (w_done) r_last_d <= (r_state == GNT_D);
  end

  assign w_pick_d = !r_last_d;
`else
  assign w_pick_d = 1'b1;
`endif

  assign w_owner_valid = (r_state == GNT_I) ? ivalid :
                         (r_state == GNT_D) ? dvalid : 1'b0;
  // A same-cycle mready beats the timeout, so the forced path requires !mready.
  assign w_to   = (TIMEOUT_CYCLES != 0) && w_owner_valid && !mready && (r_cnt == TO_LAST);
  assign w_done = w_owner_valid && (mready || w_to);

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clock) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_next;
  end

  always_ff @(posedge clock) begin
    if (reset || r_state == IDLE || w_done) r_cnt <= '0;
    else if (!mready)                       r_cnt <= r_cnt + 16'd1;
  end

  // NOTE: every combinational output gets a default first so no path can infer a latch.
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: begin
        if (dvalid && ivalid) w_next = w_pick_d ? GNT_D : GNT_I;
        else if (dvalid)      w_next = GNT_D;
        else if (ivalid)      w_next = GNT_I;
      end
      GNT_I: begin
        if (!ivalid)     w_next = IDLE;
        else if (w_done) w_next = dvalid ? GNT_D : IDLE;
      end
      GNT_D: begin
        if (!dvalid)     w_next = IDLE;
        else if (w_done) w_next = ivalid ? GNT_I : IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  always_comb begin
    mvalid = 1'b0;
    maddr  = '0;
    mwdata = '0;
    mwstb  = '0;
    mwrite = 1'b0;
    iready = 1'b0;
    dready = 1'b0;
    idata  = mrdata;
    drdata = mrdata;
    busy   = 1'b0;
    to_err = 1'b0;
    // Reset is synchronous, so outputs are explicitly held quiet while it is asserted.
    if (!reset) begin
      case (r_state)
        GNT_I: begin
          busy   = 1'b1;
          mvalid = ivalid && !w_to;
          maddr  = iaddr;
          iready = w_done;
          idata  = w_to ? TO_RDATA : mrdata;
          to_err = w_to;
        end
        GNT_D: begin
          busy   = 1'b1;
          mvalid = dvalid && !w_to;
          maddr  = daddr;
          mwdata = dwdata;
          mwstb  = dwstb;
          mwrite = dwrite;
          dready = w_done;
          drdata = w_to ? TO_RDATA : mrdata;
          to_err = w_to;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fwrisc_mem_arbiter.sv
// Directed self-checking bench for fwrisc_mem_arbiter, built with TIMEOUT_CYCLES=4.
module tb_fwrisc_mem_arbiter;

`ifdef FWRISC_MEM_ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic        clock = 1'b0;
  logic        reset;
  logic        ivalid, dvalid, dwrite, mready;
  logic [31:0] iaddr, daddr, dwdata, mrdata;
  logic [3:0]  dwstb;
  logic        iready, dready, mvalid, mwrite, busy, to_err;
  logic [31:0] idata, drdata, maddr, mwdata;
  logic [3:0]  mwstb;

  int checks = 0;
  int errors = 0;

  fwrisc_mem_arbiter #(.TIMEOUT_CYCLES(4), .TO_RDATA(32'hDEADBEEF)) dut (
    .clock(clock), .reset(reset),
    .ivalid(ivalid), .iaddr(iaddr), .iready(iready), .idata(idata),
    .dvalid(dvalid), .daddr(daddr), .dwdata(dwdata), .dwstb(dwstb), .dwrite(dwrite),
    .dready(dready), .drdata(drdata),
    .mvalid(mvalid), .maddr(maddr), .mwdata(mwdata), .mwstb(mwstb), .mwrite(mwrite),
    .mrdata(mrdata), .mready(mready), .busy(busy), .to_err(to_err)
  );

  always #5 clock = ~clock;

  // Status bits: {busy, mvalid, iready, dready, to_err, mwrite}
  function automatic logic [5:0] st();
    st = {busy, mvalid, iready, dready, to_err, mwrite};
  endfunction

  task automatic next_cycle();
    @(posedge clock);
    #1;
  endtask

  task automatic idle_inputs();
    ivalid = 0; iaddr = 0; dvalid = 0; daddr = 0; dwdata = 0;
    dwstb = 0; dwrite = 0; mready = 0; mrdata = 0;
  endtask

  task automatic test_reset();
    reset = 1; ivalid = 1; iaddr = 32'h10; dvalid = 1; daddr = 32'h20;
    dwrite = 1; dwstb = 4'hF; dwdata = 32'h1; mready = 1; mrdata = 32'h5555AAAA;
    repeat (2) next_cycle();
    @(negedge clock);
    checks++; if (st() !== 6'b0) begin errors++; $display("FAIL reset_status: got %b want %b", st(), 6'b0); end
    checks++; if (maddr !== 32'h0 || mwstb !== 4'h0) begin errors++; $display("FAIL reset_bus: maddr %h mwstb %h want 0", maddr, mwstb); end
    checks++; if (idata !== 32'h5555AAAA || drdata !== 32'h5555AAAA) begin errors++; $display("FAIL reset_rdata: idata %h drdata %h want 5555aaaa", idata, drdata); end
    next_cycle();
    reset = 0; idle_inputs();
    @(negedge clock);
    checks++; if (st() !== 6'b0) begin errors++; $display("FAIL reset_idle: got %b want %b", st(), 6'b0); end
  endtask

  task automatic test_single_fetch();
    next_cycle();
    ivalid = 1; iaddr = 32'h100;
    @(negedge clock);
    checks++; if (st() !== 6'b0) begin errors++; $display("FAIL fetch_c0: got %b want %b", st(), 6'b0); end
    next_cycle();
    mrdata = 32'h11223344;
    @(negedge clock);
    checks++; if (st() !== 6'b110000 || maddr !== 32'h100) begin errors++; $display("FAIL fetch_c1: status %b maddr %h want 110000 00000100", st(), maddr); end
    next_cycle();
    mready = 1;
    @(negedge clock);
    checks++; if (st() !== 6'b111000 || idata !== 32'h11223344) begin errors++; $display("FAIL fetch_c2: status %b idata %h want 111000 11223344", st(), idata); end
    next_cycle();
    ivalid = 0; mready = 0;
    @(negedge clock);
    checks++; if (st() !== 6'b0) begin errors++; $display("FAIL fetch_c3: got %b want %b", st(), 6'b0); end
  endtask

  task automatic test_simultaneous();
    ivalid = 1; iaddr = 32'h200; dvalid = 1; daddr = 32'h2000; dwrite = 1;
    dwdata = 32'hCAFEF00D; dwstb = 4'b0011; mready = 1;
    next_cycle();
    @(negedge clock);
    checks++; if (st() !== 6'b110101 || maddr !== 32'h2000 || mwstb !== 4'b0011 || mwdata !== 32'hCAFEF00D) begin
      errors++; $display("FAIL simul_data: status %b maddr %h mwstb %b mwdata %h want 110101 00002000 0011 cafef00d", st(), maddr, mwstb, mwdata); end
    next_cycle();
    dvalid = 0; dwrite = 0; dwstb = 0;
    @(negedge clock);
    checks++; if (st() !== 6'b111000 || maddr !== 32'h200 || mwstb !== 4'h0) begin
      errors++; $display("FAIL simul_fetch: status %b maddr %h mwstb %b want 111000 00000200 0000", st(), maddr, mwstb); end
    next_cycle();
    ivalid = 0; mready = 0;
    @(negedge clock);
    checks++; if (st() !== 6'b0) begin errors++; $display("FAIL simul_idle: got %b want %b", st(), 6'b0); end
  endtask

  // Serve data alone so last-served is D, then raise both requests together.
  task automatic test_priority();
    logic [1:0]  exp1, exp2;
    logic [31:0] a1, a2;
    exp1 = RR ? 2'b10 : 2'b01;
    exp2 = RR ? 2'b01 : 2'b10;
    a1   = RR ? 32'h300 : 32'h2008;
    a2   = RR ? 32'h2008 : 32'h300;
    dvalid = 1; daddr = 32'h2004; mready = 1;
    next_cycle();
    @(negedge clock);
    checks++; if (st() !== 6'b110100) begin errors++; $display("FAIL prio_data_only: got %b want %b", st(), 6'b110100); end
    next_cycle();
    dvalid = 0;
    @(negedge clock);
    ivalid = 1; iaddr = 32'h300; dvalid = 1; daddr = 32'h2008;
    next_cycle();
    @(negedge clock);
    checks++; if ({iready, dready} !== exp1 || maddr !== a1) begin
      errors++; $display("FAIL prio_first: ready %b maddr %h want %b %h", {iready, dready}, maddr, exp1, a1); end
    next_cycle();
    if (exp1 == 2'b10) ivalid = 0; else dvalid = 0;
    @(negedge clock);
    checks++; if ({iready, dready} !== exp2 || maddr !== a2 || busy !== 1'b1) begin
      errors++; $display("FAIL prio_second: ready %b maddr %h busy %b want %b %h 1", {iready, dready}, maddr, busy, exp2, a2); end
    next_cycle();
    ivalid = 0; dvalid = 0; mready = 0;
    @(negedge clock);
    checks++; if (st() !== 6'b0) begin errors++; $display("FAIL prio_idle: got %b want %b", st(), 6'b0); end
  endtask

  task automatic test_back_to_back();
    logic exp_d;
    exp_d = !RR;
    ivalid = 1; iaddr = 32'h400; dvalid = 1; daddr = 32'h3000; mready = 1;
    for (int k = 0; k < 4; k++) begin
      next_cycle();
      @(negedge clock);
      checks++; if ({iready, dready} !== {!exp_d, exp_d} || maddr !== (exp_d ? 32'h3000 : 32'h400) || busy !== 1'b1) begin
        errors++; $display("FAIL b2b_%0d: ready %b maddr %h busy %b want %b %h 1", k, {iready, dready}, maddr, busy,
                           {!exp_d, exp_d}, exp_d ? 32'h3000 : 32'h400); end
      exp_d = !exp_d;
    end
    next_cycle();
    ivalid = 0; dvalid = 0;
    @(negedge clock);
    checks++; if (st() !== 6'b100000) begin errors++; $display("FAIL b2b_drop: got %b want %b", st(), 6'b100000); end
    next_cycle();
    mready = 0;
    @(negedge clock);
    checks++; if (st() !== 6'b0) begin errors++; $display("FAIL b2b_idle: got %b want %b", st(), 6'b0); end
  endtask

  task automatic test_timeout();
    dvalid = 1; daddr = 32'h3000; mready = 0; mrdata = 32'h0BADF00D;
    for (int k = 1; k <= 3; k++) begin
      next_cycle();
      @(negedge clock);
      checks++; if (st() !== 6'b110000) begin errors++; $display("FAIL to_wait_%0d: got %b want %b", k, st(), 6'b110000); end
    end
    next_cycle();
    @(negedge clock);
    checks++; if (st() !== 6'b100110 || drdata !== 32'hDEADBEEF) begin
      errors++; $display("FAIL to_fire: status %b drdata %h want 100110 deadbeef", st(), drdata); end
    next_cycle();
    dvalid = 0;
    @(negedge clock);
    checks++; if (st() !== 6'b0) begin errors++; $display("FAIL to_idle: got %b want %b", st(), 6'b0); end
    // mready arriving in the timeout cycle completes normally.
    dvalid = 1;
    repeat (4) next_cycle();
    mready = 1; mrdata = 32'h12345678;
    @(negedge clock);
    checks++; if (st() !== 6'b110100 || drdata !== 32'h12345678) begin
      errors++; $display("FAIL to_mready_wins: status %b drdata %h want 110100 12345678", st(), drdata); end
    next_cycle();
    dvalid = 0; mready = 0;
    @(negedge clock);
    checks++; if (st() !== 6'b0) begin errors++; $display("FAIL to_mready_idle: got %b want %b", st(), 6'b0); end
  endtask

  task automatic test_drop();
    dvalid = 1; daddr = 32'h3100;
    next_cycle();
    @(negedge clock);
    checks++; if (st() !== 6'b110000) begin errors++; $display("FAIL drop_grant: got %b want %b", st(), 6'b110000); end
    next_cycle();
    dvalid = 0;
    @(negedge clock);
    checks++; if (st() !== 6'b100000) begin errors++; $display("FAIL drop_same_cycle: got %b want %b", st(), 6'b100000); end
    next_cycle();
    @(negedge clock);
    checks++; if (st() !== 6'b0) begin errors++; $display("FAIL drop_idle: got %b want %b", st(), 6'b0); end
  endtask

  task automatic test_reset_mid();
    dvalid = 1; daddr = 32'h3200; mready = 0;
    next_cycle();
    @(negedge clock);
    checks++; if (st() !== 6'b110000) begin errors++; $display("FAIL rmid_grant: got %b want %b", st(), 6'b110000); end
    next_cycle();
    reset = 1;
    @(negedge clock);
    checks++; if (st() !== 6'b0) begin errors++; $display("FAIL rmid_during: got %b want %b", st(), 6'b0); end
    next_cycle();
    reset = 0; dvalid = 0; ivalid = 1; iaddr = 32'h500;
    @(negedge clock);
    checks++; if (st() !== 6'b0) begin errors++; $display("FAIL rmid_after: got %b want %b", st(), 6'b0); end
    next_cycle();
    mready = 1; mrdata = 32'hA5A5A5A5;
    @(negedge clock);
    checks++; if (st() !== 6'b111000 || maddr !== 32'h500 || idata !== 32'hA5A5A5A5) begin
      errors++; $display("FAIL rmid_fetch: status %b maddr %h idata %h want 111000 00000500 a5a5a5a5", st(), maddr, idata); end
    next_cycle();
    ivalid = 0; mready = 0;
    @(negedge clock);
    checks++; if (st() !== 6'b0) begin errors++; $display("FAIL rmid_idle: got %b want %b", st(), 6'b0); end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: time %0t reached limit 100000 without finishing", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    idle_inputs();
    test_reset();
    test_single_fetch();
    test_simultaneous();
    test_priority();
    test_back_to_back();
    test_timeout();
    test_drop();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule

// File: doc/fwrisc_mem_arbiter.md
Name: fwrisc_mem_arbiter

Overview:
- Shares one external memory port between the fwrisc core's instruction-fetch port (iaddr/ivalid/iready) and data port (dvalid/daddr/...).
- Sits between the core top level and a single-ported SRAM or bus bridge.
- Grants one requester at a time and holds the grant until the memory completes or a timeout fires.
- Steers read data and ready back to the owner only.

Parameters:
- TIMEOUT_CYCLES, 0, grant cycles without mready before forced completion; 0 disables timeout (range 0..65535).
- TO_RDATA, 32'hDEADBEEF, read data returned to the requester on a forced completion.

Ports:
- clock  input  1  clock
- reset  input  1  synchronous, active-high reset
- ivalid  input  1  fetch request
- iaddr  input  32  fetch address
- iready  output  1  fetch complete
- idata  output  32  fetch read data
- dvalid  input  1  data request
- daddr  input  32  data address
- dwdata  input  32  data write data
- dwstb  input  4  data byte strobes
- dwrite  input  1  data write (1) / read (0)
- dready  output  1  data complete
- drdata  output  32  data read data
- mvalid  output  1  memory request
- maddr  output  32  memory address
- mwdata  output  32  memory write data
- mwstb  output  4  memory byte strobes
- mwrite  output  1  memory write
- mrdata  input  32  memory read data
- mready  input  1  memory complete (qualified by mvalid)
- busy  output  1  grant active (state != IDLE)
- to_err  output  1  one-cycle pulse on forced completion

Behaviour:
- Requester protocol: valid is held with stable address/data until the matching ready. A request completes in the cycle where mvalid && mready, or on a timeout.
- State register with three states: IDLE, GNT_I, GNT_D.
  - Reset: state is IDLE, timeout counter 0, last-served flag = I.
  - Every output is 0 during reset and in IDLE, except idata/drdata, which show mrdata.
- In IDLE:
  - Only dvalid set: GNT_D next cycle.
  - Only ivalid set: GNT_I next cycle.
  - Both set: GNT_D next cycle (fixed priority, see Optional Feature).
  - Neither set: stay in IDLE.
  - Latency: request seen in cycle N drives mvalid=1 in cycle N+1. Minimum transaction is 2 cycles when mready is high on the first granted cycle.
- In GNT_x:
  - mvalid = xvalid. maddr/mwdata/mwstb/mwrite come from the owner combinationally; fetch grants drive mwrite=0 and mwstb=4'h0.
  - xready = mready. idata = drdata = mrdata at all times; only the owner's ready qualifies it.
  - The non-owner's ready is 0.
- Completion cycle re-arbitration:
  - The completing requester's valid is ignored.
  - Next state is the other requester's grant if its valid is set, otherwise IDLE. No bubble when the other requester is waiting.
  - last-served flag is updated to the completing requester.
- Owner drops valid before completion (core soft reset):
  - mvalid falls the same cycle; state goes to IDLE next cycle.
  - No ready is issued and to_err stays 0.
- Timeout (TIMEOUT_CYCLES>0):
  - 16-bit counter clears on entering a grant and increments each granted cycle without mready.
  - When the counter reaches TIMEOUT_CYCLES−1 without mready, the arbiter forces completion in that cycle:
    - owner ready=1;
    - owner rdata=TO_RDATA;
    - mvalid=0;
    - to_err=1 for one cycle.
  - Re-arbitration then follows the completion-cycle rules.
  - mready arriving in the same cycle as the timeout wins: normal completion, to_err=0.
- Reset mid-transaction: state is IDLE next edge, mvalid=0, and no ready is issued to either requester.

Optional Feature:
- Macro: FWRISC_MEM_ARB_RR_EN.
- Defined: when both requesters are valid in IDLE, or the other requester is waiting at completion, the grant goes to the requester opposite the last-served flag (round-robin).
- Undefined: data has fixed priority over fetch, and the last-served flag is not implemented.

Test Plan:
- Single fetch, ivalid=1 iaddr=0x100, mready one cycle after mvalid → mvalid in cycle 1, maddr=0x100, mwrite=0, iready pulse in cycle 2 with idata=mrdata, dready=0 throughout.
- Simultaneous ivalid+dvalid (daddr=0x2000, write, dwstb=4'b0011) →
  - RR undefined: data served first with mwrite=1, mwstb=4'b0011, then fetch with no IDLE bubble; busy held high.
  - RR defined, last-served=D: fetch is served first.
- Back-to-back fetches with dvalid held continuously → RR defined: grants alternate I,D,I,D; undefined: D completes first, then I.
- TIMEOUT_CYCLES=4, mready held 0 → on 4th granted cycle: dready=1, drdata=0xDEADBEEF, to_err=1 for one cycle, state returns to IDLE.
- Owner drops dvalid mid-grant → mvalid=0 the same cycle, IDLE next cycle, no dready, to_err=0.
- Reset asserted during GNT_D with mready=0 → next cycle: mvalid=0, busy=0, iready=dready=0; a fresh ivalid after reset is granted normally.
